// File: rtl/swap_check_sequencer_if.sv
// Job/result handshake bundle for swap_check_sequencer.
// master = job producer and result consumer, slave = the sequencer.
interface swap_check_sequencer_if #(
  parameter int W    = 32,
  parameter int NPTS = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [NPTS*W-1:0] in_xs;
  logic [NPTS*W-1:0] in_ys;
  logic              out_valid;
  logic              out_ready;
  logic              out_res;
  logic              out_timeout;
  logic [7:0]        out_tag;

  modport master (
    output in_valid, in_xs, in_ys, out_ready,
    input  in_ready, out_valid, out_res, out_timeout, out_tag
  );

  modport slave (
    input  in_valid, in_xs, in_ys, out_ready,
    output in_ready, out_valid, out_res, out_timeout, out_tag
  );
endinterface

// File: rtl/swap_check_sequencer.sv
// Buffers six-point jobs in a FIFO and runs them one at a time on a checkswap
// checker, returning a tagged result (or a timeout) per job.
module swap_check_sequencer #(
  parameter int W           = 32,
  parameter int NPTS        = 6,
  parameter int DEPTH       = 4,
  parameter int LOAD_CYCLES = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  swap_check_sequencer_if.slave bus,
  output logic                  chk_rst,
  output logic [NPTS*W-1:0]     chk_xs,
  output logic [NPTS*W-1:0]     chk_ys,
  input  logic                  chk_res,
  input  logic                  chk_complete,
  output logic                  busy,
  output logic [15:0]           jobs_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES);
  localparam logic [TW-1:0] RUN_LAST   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
  state_t state, state_next;

  logic [NPTS*W-1:0] xs_mem  [DEPTH];
  logic [NPTS*W-1:0] ys_mem  [DEPTH];
  logic [7:0]        tag_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [7:0]        accept_cnt;
  logic [LW-1:0]     load_cnt;
  logic [TW-1:0]     run_cnt;
  logic              push, pop, empty, full;

  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_COUNT);
    push  = bus.in_valid && !full;
    pop   = (state == IDLE) && !empty;
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = (state == HOLD);
  // Checker is held in reset everywhere except RUN so it never sees stale data.
  assign chk_rst       = (state != RUN);
  assign busy          = (state != IDLE) || !empty;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = LOAD;
      LOAD:    if (load_cnt == LOAD_LAST) state_next = RUN;
      RUN:     if (chk_complete || run_cnt == RUN_LAST) state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      xs_mem[wr_ptr]  <= bus.in_xs;
      ys_mem[wr_ptr]  <= bus.in_ys;
      tag_mem[wr_ptr] <= accept_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      accept_cnt      <= '0;
      load_cnt        <= '0;
      run_cnt         <= '0;
      chk_xs          <= '0;
      chk_ys          <= '0;
      bus.out_tag     <= '0;
      bus.out_res     <= 1'b0;
      bus.out_timeout <= 1'b0;
      jobs_done       <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        accept_cnt <= accept_cnt + 8'd1;
      end
      if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        chk_xs      <= xs_mem[rd_ptr];
        chk_ys      <= ys_mem[rd_ptr];
        bus.out_tag <= tag_mem[rd_ptr];
        load_cnt    <= LW'(1);
      end
      if (state == LOAD && load_cnt != LOAD_LAST) load_cnt <= load_cnt + LW'(1);
      if (state == LOAD && state_next == RUN) run_cnt <= TW'(1);
      if (state == RUN) begin
        run_cnt <= run_cnt + TW'(1);
        // Completion wins over a timeout landing on the same cycle.
        if (chk_complete) begin
          bus.out_res     <= chk_res;
          bus.out_timeout <= 1'b0;
        end else if (run_cnt == RUN_LAST) begin
          bus.out_res     <= 1'b0;
          bus.out_timeout <= 1'b1;
        end
      end
      if (state == HOLD && bus.out_ready) jobs_done <= jobs_done + 16'd1;
    end
  end
endmodule
